// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM encodings, PC step and target-select codes.
package pc_sequencer_pkg;

    typedef enum logic {
        SEQ   = 1'b0,
        DELAY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TSEL_NONE   = 2'd0,
        TSEL_BRANCH = 2'd1,
        TSEL_JUMP   = 2'd2,
        TSEL_JR     = 2'd3
    } tsel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/lshift28.sv
// Jump index shifter: word index to 28-bit byte offset.
module lshift28 (
    input  logic [25:0] in,
    output logic [27:0] out
);

    assign out = {in, 2'b00};

endmodule

// File: rtl/pc_sequencer_branch_target.sv
// Branch target: sign-extended word offset added to the delay-slot address.
module pc_sequencer_branch_target (
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    output logic [31:0] target
);

    logic [31:0] offset;

    assign offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign target = pc_plus4 + offset;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the MIPS core; redirects after a single branch delay slot.
// state | meaning
// SEQ   | sequential fetch, a taken transfer latches its target
// DELAY | fetching the delay slot, next pc is the latched target
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic        is_jump,
    input  logic        is_jr,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] jidx26,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        in_delay_slot,
    output logic        cti_in_slot
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        cti_q, cti_d;

    logic [31:0] pc_plus4;
    logic [27:0] jump_offset;
    logic [31:0] branch_tgt;
    logic [31:0] sel_target;
    logic        take;
    tsel_t       tsel;

    assign pc_plus4  = pc_q + PC_STEP;
    assign link_addr = pc_plus4 + PC_STEP;

    lshift28 u_lshift28 (
        .in  (jidx26),
        .out (jump_offset)
    );

    pc_sequencer_branch_target u_branch_target (
        .pc_plus4 (pc_plus4),
        .imm16    (imm16),
        .target   (branch_tgt)
    );

    assign take = instr_valid & (is_jump | is_jr | (is_branch & branch_taken));

    always_comb begin
        tsel = TSEL_NONE;
        if (is_jr)
            tsel = TSEL_JR;
        else if (is_jump)
            tsel = TSEL_JUMP;
        else if (is_branch)
            tsel = TSEL_BRANCH;
    end

    always_comb begin
        sel_target = pc_plus4;
        case (tsel)
            TSEL_JR:     sel_target = jr_target;
            TSEL_JUMP:   sel_target = {pc_plus4[31:28], jump_offset};
            TSEL_BRANCH: sel_target = branch_tgt;
            default:     sel_target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        cti_d    = cti_q;
        if (!stall) begin
            case (state_q)
                SEQ: begin
                    pc_d = pc_plus4;
                    if (take) begin
                        target_d = sel_target;
                        state_d  = DELAY;
                    end
                end
                DELAY: begin
                    // A transfer in the slot is dropped but flagged until reset.
                    pc_d    = target_q;
                    state_d = SEQ;
                    if (take)
                        cti_d = 1'b1;
                end
                default: state_d = SEQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEQ;
            pc_q     <= RESET_PC;
            target_q <= 32'd0;
            cti_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cti_q    <= cti_d;
        end
    end

    assign pc            = pc_q;
    assign in_delay_slot = (state_q == DELAY);
    assign cti_in_slot   = cti_q;

endmodule
